// File: rtl/alu_pkg.sv
// Shared types for alu_pipe: the opcode encoding and the per-stage payload.
package alu_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [2:0] {
    OP_NOT = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } alu_op_e;

  // The result field is sized for the widest legal DATA_W plus carry/borrow.
  typedef struct packed {
    logic [MAX_W:0] res;
    logic           err;
  } alu_payload_t;

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/payload register slice of the alu_pipe result pipeline.
module alu_pipe_stage
  import alu_pkg::*;
(
  input  logic         clk_i,
  input  logic         arst_n,
  input  logic         load_i,
  input  logic         valid_i,
  input  alu_payload_t payload_i,
  output logic         valid_o,
  output alu_payload_t payload_o
);

  logic         valid_q, valid_d;
  alu_payload_t payload_q, payload_d;

  assign valid_d   = load_i ? valid_i : valid_q;
  assign payload_d = load_i ? payload_i : payload_q;

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/alu_pipe.sv
// Three-channel join ALU with a PIPE_DEPTH-deep elastic result pipeline.
// Build option ALU_PIPE_DIV0_FLAG_EN adds the out_err divide/modulo-by-zero flag.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PIPE_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              arst_n,
  input  logic [DATA_W-1:0] in_A,
  input  logic              in_A_valid,
  output logic              in_A_ready,
  input  logic [DATA_W-1:0] in_B,
  input  logic              in_B_valid,
  output logic              in_B_ready,
  input  logic [2:0]        opcode,
  input  logic              opcode_valid,
  output logic              opcode_ready,
  output logic [DATA_W:0]   out,
  output logic              out_valid,
`ifdef ALU_PIPE_DIV0_FLAG_EN
  output logic              out_err,
`endif
  input  logic              out_ready
);

  logic         stage_v   [PIPE_DEPTH];
  logic         stage_ld  [PIPE_DEPTH];
  alu_payload_t stage_pay [PIPE_DEPTH];

  logic         can_load;
  logic         accept;
  logic [DATA_W:0] res_d;
  logic         err_d;
  alu_payload_t pay_d;

  // Readies are forced low while reset is held, not just after the stages clear.
  assign can_load     = stage_ld[0] & arst_n;
  assign in_A_ready   = in_B_valid & opcode_valid & can_load;
  assign in_B_ready   = in_A_valid & opcode_valid & can_load;
  assign opcode_ready = in_A_valid & in_B_valid & can_load;
  assign accept       = in_A_valid & in_B_valid & opcode_valid & can_load;

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (alu_op_e'(opcode))
      OP_NOT: res_d = {1'b0, ~in_A};
      OP_ADD: res_d = {1'b0, in_A} + {1'b0, in_B};
      OP_SUB: res_d = {1'b0, in_A} - {1'b0, in_B};
      OP_DIV: begin
        if (in_B == '0) begin
`ifdef ALU_PIPE_DIV0_FLAG_EN
          err_d = 1'b1;
          res_d = '0;
`else
          res_d = {1'b0, {DATA_W{1'b1}}};
`endif
        end else begin
          res_d = {1'b0, in_A / in_B};
        end
      end
      OP_MOD: begin
        if (in_B == '0) begin
`ifdef ALU_PIPE_DIV0_FLAG_EN
          err_d = 1'b1;
          res_d = '0;
`else
          res_d = {1'b0, in_A};
`endif
        end else begin
          res_d = {1'b0, in_A % in_B};
        end
      end
      OP_AND: res_d = {1'b0, in_A & in_B};
      OP_OR:  res_d = {1'b0, in_A | in_B};
      OP_XOR: res_d = {1'b0, in_A ^ in_B};
      default: res_d = '0;
    endcase
  end

  always_comb begin
    pay_d              = '0;
    pay_d.res[DATA_W:0] = res_d;
    pay_d.err          = err_d;
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_stage
    logic         v_in;
    alu_payload_t p_in;

    if (k == 0) begin : g_first
      assign v_in = accept;
      assign p_in = pay_d;
    end else begin : g_next
      assign v_in = stage_v[k-1];
      assign p_in = stage_pay[k-1];
    end

    // A stage loads when empty or when its successor is taking its content.
    if (k == PIPE_DEPTH - 1) begin : g_last_ld
      assign stage_ld[k] = ~stage_v[k] | out_ready;
    end else begin : g_mid_ld
      assign stage_ld[k] = ~stage_v[k] | stage_ld[k+1];
    end

    alu_pipe_stage u_stage (
      .clk_i     (clk_i),
      .arst_n    (arst_n),
      .load_i    (stage_ld[k]),
      .valid_i   (v_in),
      .payload_i (p_in),
      .valid_o   (stage_v[k]),
      .payload_o (stage_pay[k])
    );
  end

  assign out_valid = stage_v[PIPE_DEPTH-1];
  assign out       = stage_pay[PIPE_DEPTH-1].res[DATA_W:0];
`ifdef ALU_PIPE_DIV0_FLAG_EN
  assign out_err   = stage_pay[PIPE_DEPTH-1].err;
`endif

  logic unused_payload;
  assign unused_payload = ^stage_pay[PIPE_DEPTH-1];

endmodule
